// File: rtl/dash_led_sweep.sv
// dash_led_sweep: on each trigger rising edge, sweeps a TRAIL_LEN-wide trail across led[15:0] (dir latched at accept), then cools down; ports: basys_3_clock, reset, dash_trigger, player_facing_left -> led, dash_ready, dash_busy, dash_accepted
module dash_led_sweep #(
  parameter int STEP_CYCLES     = 2_500_000,
  parameter int TRAIL_LEN       = 3,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic        basys_3_clock,
  input  logic        reset,
  input  logic        dash_trigger,
  input  logic        player_facing_left,
  output logic [15:0] led,
  output logic        dash_ready,
  output logic        dash_busy,
  output logic        dash_accepted
);
  typedef enum logic [1:0] {IDLE, SWEEP, COOLDOWN} state_t;
  localparam logic [4:0] LAST = 5'(14 + TRAIL_LEN);
  state_t state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [4:0] k, k_n;
  logic dir, dir_n, trig_prev, req, acc_n;
  logic [15:0] led_n;
  function automatic logic [15:0] pat(input logic [4:0] kk, input logic d);
    logic [15:0] p, r;
    for (int i = 0; i < 16; i++) p[i] = (5'(i) <= kk) && (5'(i + TRAIL_LEN) > kk);
    r = {<<{p}};
    return d ? p : r;
  endfunction
  assign req = dash_trigger & ~trig_prev;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 32'd1;
    k_n     = k;
    dir_n   = dir;
    acc_n   = 1'b0;
    led_n   = 16'h0000;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req) begin
          state_n = SWEEP;
          k_n     = '0;
          dir_n   = player_facing_left;
          acc_n   = 1'b1;
          led_n   = pat(5'd0, player_facing_left);
        end
      end
      SWEEP: begin
        led_n = pat(k, dir);
        if (cnt == 32'(STEP_CYCLES - 1)) begin
          cnt_n = '0;
          if (k == LAST) begin
            state_n = COOLDOWN_CYCLES > 0 ? COOLDOWN : IDLE;
            led_n   = 16'h0000;
          end else begin
            k_n   = k + 5'd1;
            led_n = pat(k + 5'd1, dir);
          end
        end
      end
      COOLDOWN: begin
        if (cnt == 32'(COOLDOWN_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge basys_3_clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      k             <= '0;
      dir           <= 1'b0;
      trig_prev     <= 1'b1;
      led           <= 16'h0000;
      dash_ready    <= 1'b1;
      dash_busy     <= 1'b0;
      dash_accepted <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      k             <= k_n;
      dir           <= dir_n;
      trig_prev     <= dash_trigger;
      led           <= led_n;
      dash_ready    <= state_n == IDLE;
      dash_busy     <= state_n != IDLE;
      dash_accepted <= acc_n;
    end
  end
endmodule
